// File: rtl/song_pkg.sv
// song_pkg: shared widths, entry layout, terminator constant and FSM states for the song recorder
package song_pkg;
  localparam int NOTE_W = 4;
  localparam int DUR_W = 26;
  localparam int ADDR_W = 5;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;
  localparam entry_t TERMINATOR = '{note: NOTE_REST, dur: '0};
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    TRACK = 3'd2,
    TERM  = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: saturating hold-duration counter with key-change and minimum-length flags
module hold_timer #(
  parameter int NOTE_W = song_pkg::NOTE_W,
  parameter int DUR_W = song_pkg::DUR_W,
  parameter int MIN_DURATION = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] key_i,
  input  logic [NOTE_W-1:0] cur_key_i,
  input  logic              load_i,
  input  logic              inc_i,
  output logic [DUR_W-1:0]  dur_o,
  output logic              change_o,
  output logic              qual_o
);
  localparam logic [DUR_W-1:0] MIN_DUR = DUR_W'(MIN_DURATION);
  logic [DUR_W-1:0] dur_q, dur_d;
  always_comb dur_d = load_i ? DUR_W'(1) : (inc_i && !(&dur_q)) ? dur_q + DUR_W'(1) : dur_q;
  always_ff @(posedge clk)
    if (rst) dur_q <= '0;
    else dur_q <= dur_d;
  assign dur_o = dur_q;
  assign change_o = key_i != cur_key_i;
  assign qual_o = dur_q >= MIN_DUR;
endmodule

// File: rtl/song_recorder.sv
// song_recorder: times key holds and writes {note, duration} entries plus a terminator to song memory.
// Define SONG_RECORDER_REST_EN to also record qualifying silent gaps as rest entries.
module song_recorder #(
  parameter int ADDR_W = song_pkg::ADDR_W,
  parameter int NOTE_W = song_pkg::NOTE_W,
  parameter int DUR_W = song_pkg::DUR_W,
  parameter int MIN_DURATION = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              record_start,
  input  logic              record_stop,
  input  logic [NOTE_W-1:0] user_input,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NOTE_W-1:0] mem_note,
  output logic [DUR_W-1:0]  mem_duration,
  output logic              recording,
  output logic [ADDR_W:0]   entry_count,
  output logic              full,
  output logic              key_on,
  output logic [NOTE_W-1:0] key
);
  import song_pkg::*;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  state_e state_q, state_d;
  logic [NOTE_W-1:0] cur_key_q, cur_key_d, note_q, note_d;
  logic [DUR_W-1:0] dur_q, dur_d, dur_cnt;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic full_q, full_d, we_q, we_d, entry_q, entry_d;
  logic load, inc, change, qual, keep, close, wrap;
  hold_timer #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .MIN_DURATION(MIN_DURATION)) u_timer (
    .clk(clk), .rst(rst), .key_i(user_input), .cur_key_i(cur_key_q),
    .load_i(load), .inc_i(inc), .dur_o(dur_cnt), .change_o(change), .qual_o(qual)
  );
  assign close = record_stop | change;
`ifdef SONG_RECORDER_REST_EN
  // a rest still open when recording stops is trailing silence and is dropped
  assign keep = qual & ((cur_key_q != NOTE_REST) | ~record_stop);
`else
  assign keep = qual & (cur_key_q != NOTE_REST);
`endif
  // the write that fills the last slot ends recording without a terminator
  assign wrap = we_q & entry_q & (cnt_q == LAST);
  always_comb begin
    state_d = state_q;
    cur_key_d = cur_key_q;
    note_d = note_q;
    dur_d = dur_q;
    cnt_d = cnt_q + (ADDR_W+1)'(we_q & entry_q);
    full_d = full_q;
    we_d = 1'b0;
    entry_d = 1'b0;
    load = 1'b0;
    inc = 1'b0;
    case (state_q)
      IDLE, DONE:
        if (record_start) begin
          state_d = ARMED;
          cnt_d = '0;
          full_d = 1'b0;
        end
      ARMED:
        if (record_stop) state_d = TERM;
        else if (user_input != NOTE_REST) begin
          state_d = TRACK;
          cur_key_d = user_input;
          load = 1'b1;
        end
      TRACK:
        if (close) begin
          we_d = keep;
          entry_d = keep;
          note_d = cur_key_q;
          dur_d = dur_cnt;
          if (record_stop) state_d = TERM;
          else begin
            cur_key_d = user_input;
            load = 1'b1;
          end
        end else inc = 1'b1;
      TERM: begin
        we_d = ~full_q;
        {note_d, dur_d} = TERMINATOR;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (wrap) begin
      full_d = 1'b1;
      state_d = DONE;
      we_d = 1'b0;
      entry_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cur_key_q <= '0;
      note_q <= '0;
      dur_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      we_q <= 1'b0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_key_q <= cur_key_d;
      note_q <= note_d;
      dur_q <= dur_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      we_q <= we_d;
      entry_q <= entry_d;
    end
  // reset also cancels a write already registered for this cycle
  assign mem_we = we_q & ~rst;
  assign mem_addr = cnt_q[ADDR_W-1:0];
  assign mem_note = note_q;
  assign mem_duration = dur_q;
  assign recording = (state_q == ARMED) | (state_q == TRACK) | (state_q == TERM);
  assign entry_count = cnt_q;
  assign full = full_q;
  assign key_on = (state_q == TRACK) & (cur_key_q != NOTE_REST);
  assign key = (state_q == TRACK) ? cur_key_q : '0;
endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed tests of song_recorder with MIN_DURATION = 4
module tb_song_recorder;
  localparam int AW = 5, NW = 4, DW = 26, EW = AW + NW + DW;
  logic clk = 1'b0, rst = 1'b1, record_start = 1'b0, record_stop = 1'b0;
  logic [NW-1:0] user_input = '0;
  logic mem_we, recording, full, key_on;
  logic [AW-1:0] mem_addr;
  logic [NW-1:0] mem_note, key;
  logic [DW-1:0] mem_duration;
  logic [AW:0] entry_count;
  int n_chk = 0, n_fail = 0;
  logic [EW-1:0] wr[$];
  song_recorder #(.ADDR_W(AW), .NOTE_W(NW), .DUR_W(DW), .MIN_DURATION(4)) dut (
    .clk(clk), .rst(rst), .record_start(record_start), .record_stop(record_stop),
    .user_input(user_input), .mem_we(mem_we), .mem_addr(mem_addr), .mem_note(mem_note),
    .mem_duration(mem_duration), .recording(recording), .entry_count(entry_count),
    .full(full), .key_on(key_on), .key(key)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (mem_we) wr.push_back({mem_addr, mem_note, mem_duration});
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic hold(input logic [NW-1:0] k, input int n);
    user_input = k;
    tick(n);
  endtask
  task automatic start_rec();
    wr.delete();
    record_start = 1'b1;
    tick(1);
    record_start = 1'b0;
  endtask
  task automatic stop_rec();
    user_input = '0;
    record_stop = 1'b1;
    tick(1);
    record_stop = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_chk++;
    if ({mem_we, mem_addr, mem_note, mem_duration, recording, entry_count, full, key_on, key} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%0d rec=%b cnt=%0d full=%b key_on=%b key=%0d, expected all 0",
               mem_we, mem_addr, recording, entry_count, full, key_on, key);
    end
    rst = 1'b0;
    tick(1);
  endtask
  task automatic test_basic();
    logic [EW-1:0] ew[$] = '{{5'd0, 4'd3, 26'd10}, {5'd1, 4'd0, 26'd0}};
    start_rec();
    n_chk++;
    if (recording !== 1'b1) begin n_fail++; $display("FAIL basic_armed: recording=%b, expected 1", recording); end
    hold(4'd3, 10);
    n_chk++;
    if ({key_on, key} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL basic_key: key_on=%b key=%0d, expected 1/3", key_on, key); end
    hold(4'd0, 1);
    stop_rec();
    n_chk++;
    if (recording !== 1'b1) begin n_fail++; $display("FAIL basic_term_rec: recording=%b, expected 1", recording); end
    tick(1);
    n_chk++;
    if (recording !== 1'b0) begin n_fail++; $display("FAIL basic_done_rec: recording=%b, expected 0", recording); end
    tick(3);
    n_chk++;
    if (wr.size() != ew.size()) begin n_fail++; $display("FAIL basic_count: %0d writes, expected %0d", wr.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < wr.size(); i++) begin
      n_chk++;
      if (wr[i] !== ew[i]) begin
        n_fail++;
        $display("FAIL basic_w%0d: got a=%0d n=%0d d=%0d, expected a=%0d n=%0d d=%0d", i,
                 wr[i][EW-1-:AW], wr[i][DW+:NW], wr[i][DW-1:0], ew[i][EW-1-:AW], ew[i][DW+:NW], ew[i][DW-1:0]);
      end
    end
    n_chk++;
    if (entry_count !== 6'd1) begin n_fail++; $display("FAIL basic_entries: entry_count=%0d, expected 1", entry_count); end
  endtask
  task automatic test_glitch();
    logic [EW-1:0] ew[$] = '{{5'd0, 4'd6, 26'd8}, {5'd1, 4'd0, 26'd0}};
    start_rec();
    n_chk++;
    if (entry_count !== 6'd0) begin n_fail++; $display("FAIL glitch_restart: entry_count=%0d, expected 0", entry_count); end
    hold(4'd5, 2);
    hold(4'd6, 8);
    stop_rec();
    tick(4);
    n_chk++;
    if (wr.size() != ew.size()) begin n_fail++; $display("FAIL glitch_count: %0d writes, expected %0d", wr.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < wr.size(); i++) begin
      n_chk++;
      if (wr[i] !== ew[i]) begin
        n_fail++;
        $display("FAIL glitch_w%0d: got a=%0d n=%0d d=%0d, expected a=%0d n=%0d d=%0d", i,
                 wr[i][EW-1-:AW], wr[i][DW+:NW], wr[i][DW-1:0], ew[i][EW-1-:AW], ew[i][DW+:NW], ew[i][DW-1:0]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [EW-1:0] ew[$] = '{{5'd0, 4'd3, 26'd6}, {5'd1, 4'd7, 26'd5}, {5'd2, 4'd0, 26'd0}};
    start_rec();
    hold(4'd3, 6);
    n_chk++;
    if (key !== 4'd3) begin n_fail++; $display("FAIL b2b_key3: key=%0d, expected 3", key); end
    hold(4'd7, 5);
    n_chk++;
    if ({key_on, key} !== {1'b1, 4'd7}) begin n_fail++; $display("FAIL b2b_key7: key_on=%b key=%0d, expected 1/7", key_on, key); end
    stop_rec();
    tick(4);
    n_chk++;
    if (wr.size() != ew.size()) begin n_fail++; $display("FAIL b2b_count: %0d writes, expected %0d", wr.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < wr.size(); i++) begin
      n_chk++;
      if (wr[i] !== ew[i]) begin
        n_fail++;
        $display("FAIL b2b_w%0d: got a=%0d n=%0d d=%0d, expected a=%0d n=%0d d=%0d", i,
                 wr[i][EW-1-:AW], wr[i][DW+:NW], wr[i][DW-1:0], ew[i][EW-1-:AW], ew[i][DW+:NW], ew[i][DW-1:0]);
      end
    end
    n_chk++;
    if (entry_count !== 6'd2) begin n_fail++; $display("FAIL b2b_entries: entry_count=%0d, expected 2", entry_count); end
  endtask
  task automatic test_rest();
`ifdef SONG_RECORDER_REST_EN
    logic [EW-1:0] ew[$] = '{{5'd0, 4'd2, 26'd6}, {5'd1, 4'd0, 26'd5}, {5'd2, 4'd4, 26'd6}, {5'd3, 4'd0, 26'd0}};
    logic [AW:0] ec = 6'd3;
`else
    logic [EW-1:0] ew[$] = '{{5'd0, 4'd2, 26'd6}, {5'd1, 4'd4, 26'd6}, {5'd2, 4'd0, 26'd0}};
    logic [AW:0] ec = 6'd2;
`endif
    start_rec();
    hold(4'd2, 6);
    hold(4'd0, 5);
    n_chk++;
    if ({recording, key_on, key} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rest_gap: rec=%b key_on=%b key=%0d, expected 1/0/0", recording, key_on, key);
    end
    hold(4'd4, 6);
    stop_rec();
    tick(4);
    n_chk++;
    if (wr.size() != ew.size()) begin n_fail++; $display("FAIL rest_count: %0d writes, expected %0d", wr.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < wr.size(); i++) begin
      n_chk++;
      if (wr[i] !== ew[i]) begin
        n_fail++;
        $display("FAIL rest_w%0d: got a=%0d n=%0d d=%0d, expected a=%0d n=%0d d=%0d", i,
                 wr[i][EW-1-:AW], wr[i][DW+:NW], wr[i][DW-1:0], ew[i][EW-1-:AW], ew[i][DW+:NW], ew[i][DW-1:0]);
      end
    end
    n_chk++;
    if (entry_count !== ec) begin n_fail++; $display("FAIL rest_entries: entry_count=%0d, expected %0d", entry_count, ec); end
  endtask
  task automatic test_capacity();
    logic [EW-1:0] ew[$];
    for (int i = 0; i < 32; i++) ew.push_back({5'(i), (i % 2 == 1) ? 4'd2 : 4'd1, 26'd4});
    start_rec();
    for (int i = 0; i < 32; i++) hold((i % 2 == 1) ? 4'd2 : 4'd1, 4);
    hold(4'd3, 6);
    n_chk++;
    if ({full, recording, key_on} !== 3'b100) begin
      n_fail++;
      $display("FAIL cap_flags: full=%b rec=%b key_on=%b, expected 1/0/0", full, recording, key_on);
    end
    n_chk++;
    if (entry_count !== 6'd32) begin n_fail++; $display("FAIL cap_entries: entry_count=%0d, expected 32", entry_count); end
    stop_rec();
    tick(4);
    n_chk++;
    if (wr.size() != ew.size()) begin n_fail++; $display("FAIL cap_count: %0d writes, expected %0d", wr.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < wr.size(); i++) begin
      n_chk++;
      if (wr[i] !== ew[i]) begin
        n_fail++;
        $display("FAIL cap_w%0d: got a=%0d n=%0d d=%0d, expected a=%0d n=%0d d=%0d", i,
                 wr[i][EW-1-:AW], wr[i][DW+:NW], wr[i][DW-1:0], ew[i][EW-1-:AW], ew[i][DW+:NW], ew[i][DW-1:0]);
      end
    end
  endtask
  task automatic test_reset_abort();
    start_rec();
    hold(4'd3, 5);
    hold(4'd4, 1);
    rst = 1'b1;
    #1;
    n_chk++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: mem_we=%b, expected 0", mem_we); end
    tick(1);
    n_chk++;
    if ({mem_we, mem_addr, mem_note, mem_duration, recording, entry_count, full, key_on, key} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got we=%b addr=%0d note=%0d dur=%0d rec=%b cnt=%0d full=%b key_on=%b key=%0d, expected all 0",
               mem_we, mem_addr, mem_note, mem_duration, recording, entry_count, full, key_on, key);
    end
    rst = 1'b0;
    hold(4'd5, 6);
    hold(4'd0, 2);
    n_chk++;
    if ({recording, key_on} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: rec=%b key_on=%b, expected 0/0", recording, key_on); end
    n_chk++;
    if (wr.size() != 0) begin n_fail++; $display("FAIL abort_writes: %0d writes, expected 0", wr.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_rest();
    test_capacity();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Record-mode writer for the song memory that learning/playback mode reads: each memory entry is a {note 4b, duration 26b} pair at a 5-bit address.
- Times how long the user holds each key (user_input, 0 = no key) and writes one entry per note, in play order, from address 0.
- Closes the song with a terminator entry (note 0, duration 0).
- Drives key/key_on so the existing buzzer and LED blocks give live feedback while recording.

Parameters:
- ADDR_W, 5, memory address width; capacity = 2**ADDR_W entries.
- NOTE_W, 4, note code width.
- DUR_W, 26, duration width in clk cycles.
- MIN_DURATION, 1_000_000, minimum hold (cycles) for an entry to be kept; shorter presses are glitches and are dropped.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- record_start  in  1  one-cycle pulse: begin recording at address 0.
- record_stop  in  1  one-cycle pulse: finish recording.
- user_input  in  NOTE_W  current key code; 0 = no key.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_note  out  NOTE_W  note written.
- mem_duration  out  DUR_W  duration written.
- recording  out  1  high in ARMED/TRACK/TERM.
- entry_count  out  ADDR_W+1  entries written, terminator excluded.
- full  out  1  capacity reached.
- key_on  out  1  buzzer enable (high while a nonzero key is tracked).
- key  out  NOTE_W  note currently tracked.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-recording aborts immediately. No write is issued, including one pending for the next cycle. Memory contents are untouched.
- States:
  - IDLE: record_start → ARMED; clears mem_addr, entry_count, full.
  - ARMED: waits for user_input != 0. Leading silence is never recorded. record_stop → TERM.
  - TRACK: timing cur_key.
    - dur_cnt = 1 in the first cycle a new key is sampled.
    - +1 each cycle user_input == cur_key; saturates at all-ones.
  - TERM: one cycle. Writes terminator {0,0} at mem_addr if not full, then → DONE.
  - DONE: record_start → ARMED (restart from address 0). Otherwise hold.
- Key change in TRACK (user_input != cur_key) closes the current segment.
  - Qualifying segment: cur_key != 0 and dur_cnt >= MIN_DURATION.
  - A qualifying segment is written in the next cycle: mem_we=1, mem_addr=current address, mem_note=cur_key, mem_duration=dur_cnt. Write latency is 1 cycle, registered.
  - The address/entry_count increment takes effect in the cycle after the write.
  - The new key starts timing in the same change cycle with dur_cnt=1. A direct 3→7 change loses no cycles.
  - Segments below MIN_DURATION are discarded; the address is not advanced.
- record_stop in TRACK: closes the current segment exactly as a key change would (same qualification rule), then → TERM.
- record_stop in the same cycle as a key change: one close only, then TERM.
- Full: when entry_count reaches 2**ADDR_W, set full=1 and go → DONE directly. No terminator and no further writes.
- record_start while recording is ignored.
- key_on/key: key=cur_key and key_on=(cur_key!=0) in TRACK; both 0 otherwise.

Optional Feature:
- Macro: SONG_RECORDER_REST_EN.
- Defined: gaps (cur_key == 0) in TRACK are recorded as rest entries {0, gap length} under the same MIN_DURATION rule. A trailing rest at stop is discarded. Rests never have duration 0, so they cannot be confused with the terminator.
- Undefined: gaps are timed but never written.

Decomposition:
- Shared package song_pkg: NOTE_W, DUR_W, ADDR_W, NOTE_REST = 0, TERMINATOR entry constant, state enum (IDLE, ARMED, TRACK, TERM, DONE).
- Sub-module: hold_timer. Holds the saturating DUR_W counter with load-1/increment, and flags change plus qualification. The FSM and write-port logic stay in song_recorder.

Test Plan:
- MIN_DURATION=4. start, key 3 for 10 cycles, 0, stop → write (addr0, 3, 10), then terminator (addr1, 0, 0); entry_count=1; recording falls after TERM.
- MIN_DURATION=4. key 5 for 2 cycles, then key 6 for 8 cycles, stop → only (addr0, 6, 8) is written; the 5 is dropped.
- Direct change: key 3 for 6 cycles → key 7 for 5 cycles → stop → writes (0, 3, 6) and (1, 7, 5) on consecutive writes; key tracks 3 then 7.
- Capacity: ADDR_W=5, 32 qualifying notes → the 32nd write sets full=1 and recording=0; a 33rd press produces no write and no terminator.
- With SONG_RECORDER_REST_EN: key 2 ×6, 0 ×5, key 4 ×6, stop → (2,6), (0,5), (4,6), terminator. Without the macro → (2,6), (4,6), terminator.
- rst asserted on the cycle after a key change closes a qualifying segment → mem_we stays 0; all outputs are 0 next cycle; state is IDLE.
